// File: rtl/gate_pkg.sv
// gate_pkg: shared leg state encoding, default dead time and leg index constants
package gate_pkg;
   typedef enum logic [1:0] {
      LEG_OFF  = 2'd0,
      LEG_DEAD = 2'd1,
      LEG_TOP  = 2'd2,
      LEG_BOT  = 2'd3
   } leg_state_t;
   localparam int DEAD_CYC_DEFAULT = 100;
   localparam int LEG_1 = 1;
   localparam int LEG_2 = 2;
   localparam int LEG_3 = 3;
   localparam int LEG_4 = 4;
endpackage

// File: rtl/gate_leg.sv
// gate_leg: one bridge leg FSM with dead-time counter and kill-gated gate drives
module gate_leg
   import gate_pkg::*;
#(
   parameter int DEAD_CYC = DEAD_CYC_DEFAULT,
   parameter int CNT_W    = $clog2(DEAD_CYC + 1)
) (
   input  logic clk,
   input  logic rstn,
   input  logic req_top,
   input  logic req_bot,
   input  logic kill,
   output logic gate_top,
   output logic gate_bot,
   output logic idle
);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD_CYC - 1);
   leg_state_t state_q, state_d, tgt;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb begin
      tgt = (req_top & ~req_bot) ? LEG_TOP : (req_bot & ~req_top) ? LEG_BOT : LEG_OFF;
      state_d = state_q;
      cnt_d = cnt_q;
      if (kill) begin
         state_d = LEG_DEAD;
         cnt_d = CNT_LOAD;
      end else begin
         case (state_q)
            LEG_OFF: state_d = tgt;
            LEG_TOP, LEG_BOT: begin
               if (tgt != state_q) begin
                  state_d = LEG_DEAD;
                  cnt_d = CNT_LOAD;
               end
            end
            LEG_DEAD: begin
               // requests are ignored until the count expires, so the gap can't be shortened
               if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
               else state_d = tgt;
            end
            default: state_d = LEG_DEAD;
         endcase
      end
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= LEG_DEAD;
         cnt_q <= CNT_LOAD;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
      end
   end
   assign gate_top = (state_q == LEG_TOP) & ~kill;
   assign gate_bot = (state_q == LEG_BOT) & ~kill;
   assign idle = state_q == LEG_OFF;
endmodule

// File: rtl/gate_deadtime.sv
// gate_deadtime: four-leg dead-time / shoot-through guard with sticky conflict flag
module gate_deadtime
   import gate_pkg::*;
#(
   parameter int DEAD_CYC = DEAD_CYC_DEFAULT,
   parameter int CNT_W    = $clog2(DEAD_CYC + 1)
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [4:1] req_top,
   input  logic [4:1] req_bot,
   input  logic       kill,
   input  logic       clr_conflict,
   output logic [4:1] gate_top,
   output logic [4:1] gate_bot,
   output logic [4:1] leg_idle,
   output logic       conflict
);
   if (DEAD_CYC < 1) begin : g_bad_dead
      $error("gate_deadtime: DEAD_CYC must be >= 1");
   end
   logic conflict_q, conflict_d;
   genvar i;
   for (i = LEG_1; i <= LEG_4; i++) begin : g_leg
      gate_leg #(.DEAD_CYC(DEAD_CYC), .CNT_W(CNT_W)) u_leg (
         .clk     (clk),
         .rstn    (rstn),
         .req_top (req_top[i]),
         .req_bot (req_bot[i]),
         .kill    (kill),
         .gate_top(gate_top[i]),
         .gate_bot(gate_bot[i]),
         .idle    (leg_idle[i])
      );
   end
   // a new conflict in the clearing cycle keeps the flag set
   always_comb conflict_d = (|(req_top & req_bot)) | (conflict_q & ~clr_conflict);
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) conflict_q <= 1'b0;
      else conflict_q <= conflict_d;
   end
   assign conflict = conflict_q;
endmodule

// File: tb/tb_gate_deadtime.sv
// tb_gate_deadtime: directed-vector check of gate_deadtime with DEAD_CYC = 4
module tb_gate_deadtime;
   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [4:1] req_top = '0;
   logic [4:1] req_bot = '0;
   logic       kill = 1'b0;
   logic       clr_conflict = 1'b0;
   logic [4:1] gate_top, gate_bot, leg_idle;
   logic       conflict;
   int         n_vec = 0;
   int         n_err = 0;

   gate_deadtime #(.DEAD_CYC(4)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .req_top     (req_top),
      .req_bot     (req_bot),
      .kill        (kill),
      .clr_conflict(clr_conflict),
      .gate_top    (gate_top),
      .gate_bot    (gate_bot),
      .leg_idle    (leg_idle),
      .conflict    (conflict)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      chk("no_overlap", {4'h0, gate_top & gate_bot}, 8'h00);
   endtask

   task automatic chk_gates(input string tag, input logic [4:1] et, input logic [4:1] eb);
      chk({tag, "_top"}, {4'h0, gate_top}, {4'h0, et});
      chk({tag, "_bot"}, {4'h0, gate_bot}, {4'h0, eb});
   endtask

   initial begin
      // 1: power-up dead interval
      req_top = 4'b0001;
      repeat (2) @(posedge clk);
      #1;
      chk_gates("rst", 4'b0000, 4'b0000);
      chk("rst_idle", {4'h0, leg_idle}, 8'h00);
      chk("rst_conflict", {7'h0, conflict}, 8'h00);
      rstn = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk_gates("pwrup_dead", 4'b0000, 4'b0000);
      end
      step();
      chk_gates("pwrup_on", 4'b0001, 4'b0000);
      // 2: switch-over TOP -> BOT on leg 1
      req_top = 4'b0000;
      req_bot = 4'b0001;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk_gates("swap_dead", 4'b0000, 4'b0000);
      end
      step();
      chk_gates("swap_on", 4'b0000, 4'b0001);
      // 3: conflict on leg 3
      req_top = 4'b0100;
      step();
      chk_gates("l3_on", 4'b0100, 4'b0001);
      chk("no_conflict", {7'h0, conflict}, 8'h00);
      req_bot = 4'b0101;
      step();
      chk_gates("l3_both", 4'b0000, 4'b0001);
      chk("conflict_set", {7'h0, conflict}, 8'h01);
      step();
      chk("conflict_hold", {7'h0, conflict}, 8'h01);
      clr_conflict = 1'b1;
      step();
      chk("conflict_set_wins", {7'h0, conflict}, 8'h01);
      req_top = 4'b0000;
      req_bot = 4'b0001;
      step();
      chk("conflict_clr", {7'h0, conflict}, 8'h00);
      clr_conflict = 1'b0;
      req_bot = 4'b0000;
      repeat (6) step();
      chk("all_idle", {4'h0, leg_idle}, 8'h0f);
      // 5: independent legs from all-off
      req_top = 4'b1000;
      req_bot = 4'b0100;
      step();
      chk_gates("indep", 4'b1000, 4'b0100);
      chk("indep_idle", {4'h0, leg_idle}, 8'h03);
      // 4: kill with plus pattern
      req_top = 4'b0001;
      req_bot = 4'b0010;
      step();
      chk_gates("plus", 4'b0001, 4'b0010);
      #1 kill = 1'b1;
      #1;
      chk_gates("kill_comb", 4'b0000, 4'b0000);
      repeat (3) step();
      chk_gates("kill_held", 4'b0000, 4'b0000);
      kill = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk_gates("kill_dead", 4'b0000, 4'b0000);
      end
      step();
      chk_gates("kill_back", 4'b0001, 4'b0010);
      // 6: async reset mid dead-count
      req_top = 4'b1001;
      req_bot = 4'b1010;
      step();
      chk("pre_rst_conflict", {7'h0, conflict}, 8'h01);
      req_top = 4'b0000;
      req_bot = 4'b0011;
      step();
      chk_gates("pre_rst", 4'b0000, 4'b0010);
      step();
      #2 rstn = 1'b0;
      #1;
      chk_gates("async_rst", 4'b0000, 4'b0000);
      chk("async_rst_conflict", {7'h0, conflict}, 8'h00);
      step();
      rstn = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk_gates("rerst_dead", 4'b0000, 4'b0000);
      end
      step();
      chk_gates("rerst_on", 4'b0000, 4'b0011);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
